// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and data/period constants.
// Imported by the receive path and its FIFO wrapper.
package uart_pkg;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_PERIOD_W   = 11;
  localparam int UART_PERIOD_MIN = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side bus of the UART receiver: pop/clear strobes in, FIFO head and status out.
// master = bus owner (CPU), slave = the receiver.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic                      i_rd;
  logic                      i_clr_err;
  logic [UART_DATA_BITS-1:0] o_dout;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      o_busy;
  logic                      o_frame_err;
  logic                      o_overrun;

  modport master (
    output i_rd, i_clr_err,
    input  o_dout, fifo_empty, fifo_full,
    input  o_busy, o_frame_err, o_overrun
  );

  modport slave (
    input  i_rd, i_clr_err,
    output o_dout, fifo_empty, fifo_full,
    output o_busy, o_frame_err, o_overrun
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: dout is the head entry, valid while !empty.
// Ports: clk, reset, push/din, pop/dout, empty, full.
module sync_fifo_fwft #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_L =
    (ADDRESS_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH:0]   level;
  logic                     push_ok;
  logic                     pop_ok;

  // Full blocks a push even when a pop lands in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH_L);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, sticky errors, show-ahead FIFO.
// Ports: clk, reset, i_period (bit period - 1), i_rxd pad, bus (slave: pop/clear in, data/status out).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [UART_PERIOD_W-1:0] i_period,
  input  logic                     i_rxd,
  uart_rx_fifo_if.slave            bus
);
  rx_state_t                 state;
  rx_state_t                 state_n;
  logic                      rxd_m;
  logic                      rxd_s;
  logic [UART_PERIOD_W-1:0]  cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      tick;
  logic                      load_half;
  logic                      shift;
  logic                      push;
  logic                      set_fe;
  logic                      frame_err;
  logic                      overrun;
  logic                      full;

  assign tick = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= i_rxd;
      rxd_s <= rxd_m;
    end
  end

  always_comb begin
    state_n   = state;
    load_half = 1'b0;
    shift     = 1'b0;
    push      = 1'b0;
    set_fe    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxd_s) begin
          load_half = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (tick) state_n = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          shift = 1'b1;
          if (bit_idx == 3'(UART_DATA_BITS-1)) state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rxd_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            set_fe  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off until the line releases so a long low is not re-read as starts.
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_n;
      // Half-period load centres every later sample in its bit.
      if (load_half)  cnt <= i_period >> 1;
      else if (tick)  cnt <= i_period;
      else            cnt <= cnt - 1'b1;
      if (state == START) bit_idx <= '0;
      else if (shift)     bit_idx <= bit_idx + 1'b1;
      if (shift) shreg <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
      frame_err <= set_fe | (frame_err & ~bus.i_clr_err);
      overrun   <= (push & full) | (overrun & ~bus.i_clr_err);
    end
  end

  sync_fifo_fwft #(
    .WIDTH         (UART_DATA_BITS),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .pop   (bus.i_rd),
    .dout  (bus.o_dout),
    .empty (bus.fifo_empty),
    .full  (full)
  );

  assign bus.fifo_full   = full;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_frame_err = frame_err;
  assign bus.o_overrun   = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frames driven on the pad, FIFO/flags
// compared against a queue-based model of the received byte stream.
module tb_uart_rx_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] period;
  logic        rxd;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  mq[$];
  bit          m_fe;
  bit          m_ov;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.ADDRESS_WIDTH(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_period (period),
    .i_rxd    (rxd),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic drive_bit(input logic v, input int p);
    rxd = v;
    repeat (p + 1) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int p);
    @(posedge clk); #1;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(b[i], p);
    drive_bit(stop_ok, p);
    drive_bit(1'b1, p);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) m_fe = 1'b1;
    else if (mq.size() == 8) m_ov = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic pop_byte(output logic [7:0] d);
    @(negedge clk);
    d = bus.o_dout;
    @(posedge clk); #1;
    bus.i_rd = 1'b1;
    @(posedge clk); #1;
    bus.i_rd = 1'b0;
  endtask

  task automatic clear_err();
    @(posedge clk); #1;
    bus.i_clr_err = 1'b1;
    @(posedge clk); #1;
    bus.i_clr_err = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", bus.fifo_empty); else n_pass++;
    n_checks++; if (bus.fifo_full !== 1'b0) $display("FAIL rst_full: got %b want 0", bus.fifo_full); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_frame_err !== 1'b0) $display("FAIL rst_fe: got %b want 0", bus.o_frame_err); else n_pass++;
    n_checks++; if (bus.o_overrun !== 1'b0) $display("FAIL rst_ov: got %b want 0", bus.o_overrun); else n_pass++;
  endtask

  task automatic test_single();
    int lat;
    logic [7:0] d;
    period = 11'd9;
    lat = 0;
    fork
      send_frame(8'h55, 1'b1, 9);
      begin
        @(posedge clk); #1;
        while (bus.fifo_empty && lat < 300) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    join
    // Start + 8 data samples + stop at mid-bit, after 2 sync and 1 detect clock.
    n_checks++; if (lat < 95 || lat > 100) $display("FAIL single_latency: got %0d want 95..100", lat); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.o_frame_err !== 1'b0 || bus.o_overrun !== 1'b0) $display("FAIL single_flags: got fe=%b ov=%b want 0 0", bus.o_frame_err, bus.o_overrun); else n_pass++;
    pop_byte(d);
    n_checks++; if (d !== 8'h55) $display("FAIL single_data: got %h want 55", d); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL single_pop_empty: got %b want 1", bus.fifo_empty); else n_pass++;
  endtask

  task automatic test_glitch();
    bit seen_busy;
    period = 11'd9;
    seen_busy = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.o_busy) seen_busy = 1'b1;
    end
    n_checks++; if (seen_busy !== 1'b1) $display("FAIL glitch_detect: got busy_seen=%b want 1", seen_busy); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL glitch_idle: got busy=%b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL glitch_empty: got %b want 1", bus.fifo_empty); else n_pass++;
    n_checks++; if (bus.o_frame_err !== 1'b0 || bus.o_overrun !== 1'b0) $display("FAIL glitch_flags: got fe=%b ov=%b want 0 0", bus.o_frame_err, bus.o_overrun); else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    logic [7:0] d;
    period = 11'd9;
    b = 8'hA5;
    @(posedge clk); #1;
    drive_bit(1'b0, 9);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 9);
    drive_bit(1'b0, 9);
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.o_frame_err !== 1'b1) $display("FAIL fe_set: got %b want 1", bus.o_frame_err); else n_pass++;
    n_checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL fe_empty: got %b want 1", bus.fifo_empty); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL fe_break_busy: got %b want 1", bus.o_busy); else n_pass++;
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL fe_break_exit: got %b want 0", bus.o_busy); else n_pass++;
    send_frame(8'h3C, 1'b1, 9);
    pop_byte(d);
    n_checks++; if (d !== 8'h3C) $display("FAIL fe_next_data: got %h want 3c", d); else n_pass++;
    clear_err();
    @(negedge clk);
    n_checks++; if (bus.o_frame_err !== 1'b0) $display("FAIL fe_clear: got %b want 0", bus.o_frame_err); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    int p;
    mq.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    p = $urandom_range(7, 12);
    period = 11'(p);
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, p);
      model_frame(8'(i), 1'b1);
      @(negedge clk);
      if (i == 6 || i == 7) begin
        n_checks++; if (bus.fifo_full !== (i == 7)) $display("FAIL ov_full_%0d: got %b want %b", i, bus.fifo_full, i == 7); else n_pass++;
      end
    end
    n_checks++; if (bus.o_overrun !== 1'b1) $display("FAIL ov_set: got %b want 1", bus.o_overrun); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      pop_byte(d);
      n_checks++; if (d !== mq[0]) $display("FAIL ov_pop_%0d: got %h want %h", i, d, mq[0]); else n_pass++;
      void'(mq.pop_front());
    end
    @(negedge clk);
    n_checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL ov_drained: got %b want 1", bus.fifo_empty); else n_pass++;
    clear_err();
    @(negedge clk);
    n_checks++; if (bus.o_overrun !== 1'b0) $display("FAIL ov_clear: got %b want 0", bus.o_overrun); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int pe;
    period = 11'd9;
    mq.delete();
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 9);
      model_frame(d, 1'b1);
    end
    // Push edge counted from the start edge: 2 sync + 1 detect, half bit, 9 bits.
    pe = 3 + (9 >> 1) + 1 + 9 * 10;
    fork
      send_frame(8'h77, 1'b1, 9);
      begin
        @(posedge clk);
        repeat (pe - 1) @(posedge clk);
        #1 bus.i_rd = 1'b1;
        @(posedge clk);
        #1 bus.i_rd = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.o_dout !== mq[1]) $display("FAIL b2b_head: got %h want %h", bus.o_dout, mq[1]); else n_pass++;
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'h77);
    @(negedge clk);
    n_checks++; if (bus.fifo_full !== 1'b0 || bus.o_overrun !== 1'b0) $display("FAIL b2b_status: got full=%b ov=%b want 0 0", bus.fifo_full, bus.o_overrun); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      pop_byte(d);
      n_checks++; if (d !== mq[0]) $display("FAIL b2b_pop_%0d: got %h want %h", i, d, mq[0]); else n_pass++;
      void'(mq.pop_front());
    end
    @(negedge clk);
    n_checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL b2b_level3: got empty=%b want 1", bus.fifo_empty); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] d;
    bit ok;
    int p;
    int npop;
    mq.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    for (int f = 0; f < 14; f++) begin
      b = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      p = $urandom_range(7, 20);
      period = 11'(p);
      send_frame(b, ok, p);
      model_frame(b, ok);
      @(negedge clk);
      n_checks++; if (bus.fifo_empty !== (mq.size() == 0) || bus.fifo_full !== (mq.size() == 8)) $display("FAIL rnd_level_%0d: got e=%b f=%b want level %0d", f, bus.fifo_empty, bus.fifo_full, mq.size()); else n_pass++;
      n_checks++; if (bus.o_frame_err !== m_fe || bus.o_overrun !== m_ov) $display("FAIL rnd_flags_%0d: got fe=%b ov=%b want %b %b", f, bus.o_frame_err, bus.o_overrun, m_fe, m_ov); else n_pass++;
      npop = $urandom_range(0, 1);
      for (int k = 0; k < npop && mq.size() > 0; k++) begin
        pop_byte(d);
        n_checks++; if (d !== mq[0]) $display("FAIL rnd_pop_%0d: got %h want %h", f, d, mq[0]); else n_pass++;
        void'(mq.pop_front());
      end
    end
    while (mq.size() > 0) begin
      pop_byte(d);
      n_checks++; if (d !== mq[0]) $display("FAIL rnd_drain: got %h want %h", d, mq[0]); else n_pass++;
      void'(mq.pop_front());
    end
    clear_err();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [7:0] d;
    period = 11'd9;
    send_frame(8'h11, 1'b1, 9);
    b = 8'hF0;
    @(posedge clk); #1;
    drive_bit(1'b0, 9);
    for (int i = 0; i < 4; i++) drive_bit(b[i], 9);
    rxd = b[4];
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", bus.o_busy); else n_pass++;
    reset = 1'b1;
    #2;
    n_checks++; if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_frame_err !== 1'b0 || bus.o_overrun !== 1'b0) $display("FAIL rstmid_outputs: got e=%b f=%b b=%b fe=%b ov=%b want 1 0 0 0 0", bus.fifo_empty, bus.fifo_full, bus.o_busy, bus.o_frame_err, bus.o_overrun); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 5; i < 8; i++) drive_bit(b[i], 9);
    drive_bit(1'b1, 9);
    drive_bit(1'b1, 9);
    @(negedge clk);
    n_checks++; if (bus.fifo_empty !== 1'b1 || bus.o_busy !== 1'b0) $display("FAIL rstmid_lost: got e=%b b=%b want 1 0", bus.fifo_empty, bus.o_busy); else n_pass++;
    send_frame(8'h0F, 1'b1, 9);
    pop_byte(d);
    n_checks++; if (d !== 8'h0F) $display("FAIL rstmid_next: got %h want 0f", d); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.fifo_empty !== 1'b1) $display("FAIL rstmid_end_empty: got %b want 1", bus.fifo_empty); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    rxd = 1'b1;
    period = 11'd9;
    bus.i_rd = 1'b0;
    bus.i_clr_err = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side UART for the Catena RISC-V FPGA core: 8N1 serial deserializer with mid-bit sampling, false-start rejection, framing/overrun detection and a show-ahead receive FIFO. It sits between the `rxd` pad and the CPU peripheral bus. It uses the same `i_period` baud convention as the transmit UART, so one divisor register serves both directions.

## Interface
- `ADDRESS_WIDTH`, 3: FIFO address bits; depth = 2^ADDRESS_WIDTH bytes.
- `clk`  in  1  data interface clock.
- `reset`  in  1  asynchronous, active-high.
- `i_period`  in  11  bit period minus one, in `clk` cycles; legal range 3..2047; must be held stable while `o_busy`=1.
- `i_rxd`  in  1  asynchronous serial input, idle high.
- `i_rd`  in  1  pop strobe; ignored when `fifo_empty`=1.
- `i_clr_err`  in  1  clears `o_frame_err` and `o_overrun`.
- `o_dout`  out  8  FIFO head byte; valid while `fifo_empty`=0. Reset: 0x00 content is don't-care.
- `fifo_empty`  out  1  FIFO level == 0. Reset: 1.
- `fifo_full`  out  1  FIFO level == depth. Reset: 0.
- `o_busy`  out  1  FSM not in IDLE. Reset: 0.
- `o_frame_err`  out  1  sticky: stop bit sampled low. Reset: 0.
- `o_overrun`  out  1  sticky: byte completed while FIFO full. Reset: 0.

## Operation
- `i_rxd` passes through a 2-flop synchronizer to give `rxd_s`. Both flops reset to 1.
- Down-counter `cnt` (11 b): "tick" when `cnt`==0. On tick, reload `i_period`. Otherwise decrement.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxd_s`==0, load `cnt` = `i_period`>>1 and go to START.
  - START, tick: if `rxd_s`==0, go to DATA with `bit_idx`=0. Otherwise go to IDLE (false start, nothing recorded).
  - DATA, tick: shift `rxd_s` into `shreg` LSB-first (`shreg` <= {`rxd_s`, `shreg`[7:1]}). After `bit_idx`==7, go to STOP.
  - STOP, tick, `rxd_s`==1: push `shreg` (or, if full, drop it and set `o_overrun`), then go to IDLE.
  - STOP, tick, `rxd_s`==0: set `o_frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxd_s`==1, then go to IDLE. This prevents a held-low line from being re-detected as start bits.
- FIFO:
  - Push is accepted iff `fifo_full`=0. This holds even if `i_rd` is asserted in the same cycle.
  - Pop is accepted iff `fifo_empty`=0.
  - Simultaneous accepted push and pop: level unchanged, both pointers advance.
  - Pointers wrap modulo depth. Level is ADDRESS_WIDTH+1 bits.
- Sticky flags: a set event in the same cycle as `i_clr_err` leaves the flag set.
- `reset` mid-frame: FSM returns to IDLE, FIFO is emptied, flags are cleared, the partial byte is lost.

## Timing
- Pin to `rxd_s`: 2 clocks.
- Start sample: (`i_period`>>1)+1 clocks after start detection.
- Each later sample: `i_period`+1 clocks after the previous one, so every sample lands at mid-bit.
- Push occurs on the clock edge after the stop-bit tick. `fifo_empty` falls and `o_dout` is valid in the following cycle.
- `o_dout` is combinational from memory at `rd_ptr` (show-ahead). After a pop, the next byte appears the next cycle.
- `fifo_empty` and `fifo_full` are combinational decodes of the registered level.
- `o_frame_err` and `o_overrun` assert on the clock edge after the stop-bit tick.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef (IDLE, START, DATA, STOP, BREAK);
  - `UART_DATA_BITS`=8;
  - `UART_PERIOD_W`=11;
  - `UART_PERIOD_MIN`=3.
- Sub-module `sync_fifo_fwft` (parameterized width and ADDRESS_WIDTH, show-ahead) holds the FIFO. It is reusable by the transmit path.
- The top level holds the synchronizer, counter, FSM, shift register and flags.

## Test plan
- Send byte 0x55 with `i_period`=9 (10 clk/bit): `fifo_empty` falls about 97 clocks after the start edge; `o_dout`=0x55; both flags stay 0; one `i_rd` pop restores `fifo_empty`=1.
- Low glitch of 3 clocks on `i_rxd` with `i_period`=9: FSM returns to IDLE at the start sample; no push; no flag set.
- Send 0xA5 with the stop bit driven low, then hold the line low for 40 clocks: `o_frame_err`=1; FIFO stays empty; FSM stays in BREAK until the line goes high; a following 0x3C is received correctly; `i_clr_err` clears the flag.
- ADDRESS_WIDTH=3, send bytes 0x00..0x08 with no pops:
  - `fifo_full`=1 after 0x07;
  - `o_overrun`=1 after 0x08;
  - eight pops return 0x00..0x07 in order, then `fifo_empty`=1.
- FIFO at level 3, `i_rd` asserted on the push cycle of 0x77: level stays 3; the head advances; 0x77 is read as the fourth byte later.
- Assert `reset` during DATA bit 4 of 0xF0: all outputs return to reset values; the next full frame 0x0F is received intact.
